prbs_checker_qi: RTL and testbench
==================================

PRBS_CHECKER_QI -- requirements
Module: prbs_checker_qi

Interface
REQ-001 Parameter LOCK_CNT, default 16: consecutive correct predictions required to declare lock.
REQ-002 Parameter BLOCK_LEN, default 64: bits per loss-of-lock evaluation block.
REQ-003 Parameter LOSS_THR, default 8: errors within one block that force loss of lock.
REQ-004 Parameter CNT_W, default 32: width of the bit and error counters.
REQ-005 clock  in  1  single system clock; all logic is on its rising edge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_enable  in  1  checker enable.
REQ-008 i_valid  in  1  received-bit strobe; a bit is accepted only when i_enable && i_valid.
REQ-009 i_bitI, i_bitQ  in  1 each  received PRBS9 bits for the I and Q lanes.
REQ-010 i_clear  in  1  synchronous clear of all counters; lock state is unaffected.
REQ-011 o_lockI, o_lockQ  out  1 each  lane locked.
REQ-012 o_errI, o_errQ  out  1 each  one-cycle error pulse.
REQ-013 o_bitCntI, o_bitCntQ, o_errCntI, o_errCntQ  out  CNT_W each  bits checked and errors counted while locked.

Function
REQ-014 Polynomial x^9+x^5+1: expected bit x[n] = x[n-5] XOR x[n-9].
REQ-015 Each lane runs an independent two-state FSM, SEARCH and LOCKED, and the lanes never interact.
REQ-016 SEARCH behaviour:
- On each accepted bit, the 9-bit history shifts in the received bit.
- The prediction is formed from the history taps (previous bit at index 0; taps at indices 4 and 8).
- A match increments the match counter; a mismatch zeroes it.
- The lane moves to LOCKED on the accepted bit that makes the match count equal LOCK_CNT.
REQ-017 LOCKED behaviour:
- The history self-advances with its own predicted bit, not the received bit.
- Received != predicted asserts o_err for one cycle, starting the cycle after the bit is accepted.
- Each mismatch increments the block error count.
REQ-018 Loss of lock:
- A block counter wraps at BLOCK_LEN accepted bits, and the block error count clears at each wrap.
- Reaching LOSS_THR errors within a block returns the lane to SEARCH on the next cycle, with the match count zeroed.
REQ-019 A cycle without an accepted bit changes nothing, and o_err is 0 in that cycle.
REQ-020 Counters increment only for bits accepted while LOCKED, and they saturate at all-ones without wrapping.
REQ-021 If i_clear coincides with an accepted bit, the clear wins and the counters read 0 on the next cycle.
REQ-022 An all-zero history in LOCKED produces no false lock; an all-zero input never reaches lock.
- A zero history predicts 0 forever, and an all-zero input matches that prediction.
- Lock additionally requires at least one 1 among the last 9 bits.

Reset
REQ-023 Asserting i_reset_n low immediately does the following:
- forces both FSMs to SEARCH;
- zeroes the histories, match counters, block counters and all counters;
- drives o_lock, o_err and the count outputs to 0.
REQ-024 Reset taken mid-lock or mid-block discards all state, and deassertion is synchronised by the integration level.

Configuration
REQ-025 With macro PRBS_CHK_COUNTERS_EN defined, the four CNT_W counters and i_clear are implemented.
REQ-026 Without PRBS_CHK_COUNTERS_EN, the counters are omitted and the count outputs are tied to 0, while i_clear is accepted and ignored.
- Lock and o_err behaviour is identical in both builds.

Structure
REQ-027 Package prbs_pkg holds the following:
- the PRBS9 tap indices (4, 8) and register width 9;
- the I and Q generator seeds 9'b010101011 and 9'b111111110;
- the lane state typedef {SEARCH, LOCKED}.
REQ-028 Sub-module prbs9_lane_chk implements one lane (FSM, history, counters), and prbs_checker_qi instantiates it twice.

Verification
REQ-029 Team PRBS9 I/Q generator drives the checker at 1 accepted bit/cycle from reset → o_lockI and o_lockQ rise on the 16th accepted bit after the first 9; the error counts stay 0 after 1000 bits.
REQ-030 Locked, one bit of I inverted at bit 200 → a single o_errI pulse one cycle later, o_errCntI = 1, o_errCntQ = 0, lock retained.
REQ-031 Locked, 8 inverted bits within one 64-bit block → o_lockI drops, then relocks 16 correct bits after the errors stop.
REQ-032 i_valid toggled every other cycle → lock after the same accepted-bit count, and o_bitCnt equals the number of accepted bits.
REQ-033 All-zero input for 100 bits → the lock outputs stay 0.
REQ-034 i_reset_n asserted mid-lock with counts nonzero → all outputs 0 in that cycle; i_clear while locked → counts 0 and lock retained.

Source files
------------

// File: rtl/prbs_checker_qi_pkg.sv
// PRBS9 constants, generator seeds and lane state encoding shared by the I/Q checker.
package prbs_pkg;

  localparam int PRBS_W = 9;
  localparam int TAP_A  = 4;
  localparam int TAP_B  = 8;

  localparam logic [PRBS_W-1:0] SEED_I = 9'b010101011;
  localparam logic [PRBS_W-1:0] SEED_Q = 9'b111111110;

  typedef logic [0:0] lane_state_t;
  localparam lane_state_t SEARCH = 1'b0;
  localparam lane_state_t LOCKED = 1'b1;

  // x[n] = x[n-5] ^ x[n-9] with hist[0] holding x[n-1]
  function automatic logic prbs9_pred(input logic [PRBS_W-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage

// File: rtl/prbs_checker_qi_if.sv
// Bit-strobe, control and status bundle between the PRBS I/Q checker and its driver.
interface prbs_checker_qi_if #(
  parameter int CNT_W = 32
);
  logic             i_enable;
  logic             i_valid;
  logic             i_bitI;
  logic             i_bitQ;
  logic             i_clear;
  logic             o_lockI;
  logic             o_lockQ;
  logic             o_errI;
  logic             o_errQ;
  logic [CNT_W-1:0] o_bitCntI;
  logic [CNT_W-1:0] o_bitCntQ;
  logic [CNT_W-1:0] o_errCntI;
  logic [CNT_W-1:0] o_errCntQ;

  modport master (
    output i_enable, i_valid, i_bitI, i_bitQ, i_clear,
    input  o_lockI, o_lockQ, o_errI, o_errQ,
    input  o_bitCntI, o_bitCntQ, o_errCntI, o_errCntQ
  );

  modport slave (
    input  i_enable, i_valid, i_bitI, i_bitQ, i_clear,
    output o_lockI, o_lockQ, o_errI, o_errQ,
    output o_bitCntI, o_bitCntQ, o_errCntI, o_errCntQ
  );
endinterface

// File: rtl/prbs_checker_qi_lane.sv
// One PRBS9 checker lane: search/lock FSM, history, block loss-of-lock and counters.
// Counters are built only with PRBS_CHK_COUNTERS_EN; otherwise they read 0 and i_clear is ignored.
//
// state  | meaning
// SEARCH | history follows received bits, counting consecutive correct predictions
// LOCKED | history self-advances, mismatches flagged and counted per block
module prbs9_lane_chk
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int BLOCK_LEN = 64,
  parameter int LOSS_THR  = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_clear,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(BLOCK_LEN + 1);
  localparam int EW = $clog2(LOSS_THR + 1);
  localparam int FW = $clog2(PRBS_W + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BLK_LOAD   = BW'(BLOCK_LEN - 1);
  localparam logic [EW-1:0] ERR_LIMIT  = EW'(LOSS_THR);
  localparam logic [FW-1:0] FILL_FULL  = FW'(PRBS_W);

  lane_state_t       r_state;
  logic [PRBS_W-1:0] r_hist;
  logic [MW-1:0]     r_match;
  logic [FW-1:0]     r_fill;
  logic [BW-1:0]     r_blk_rem;
  logic [EW-1:0]     r_blk_err;
  logic              r_err;

  logic              w_accept;
  logic              w_pred;
  logic              w_miss;
  logic              w_filled;
  logic              w_lock_hit;
  logic              w_count;
  logic [PRBS_W-1:0] w_hist_rx;
  logic [PRBS_W-1:0] w_hist_self;
  logic [EW-1:0]     w_err_sum;

  assign w_accept    = i_enable & i_valid;
  assign w_pred      = prbs9_pred(r_hist);
  assign w_miss      = i_bit ^ w_pred;
  assign w_hist_rx   = {r_hist[PRBS_W-2:0], i_bit};
  assign w_hist_self = {r_hist[PRBS_W-2:0], w_pred};
  assign w_filled    = (r_fill == FILL_FULL);
  // predictions only count once the history holds real bits, and a zero history never locks
  assign w_lock_hit  = w_filled & ~w_miss & (r_match == MATCH_LAST) & (|w_hist_rx);
  assign w_err_sum   = r_blk_err + EW'(w_miss);
  assign w_count     = w_accept & (r_state == LOCKED);

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= SEARCH;
      r_hist    <= '0;
      r_match   <= '0;
      r_fill    <= '0;
      r_blk_rem <= '0;
      r_blk_err <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
        case (r_state)
          SEARCH: begin
            r_hist <= w_hist_rx;
            if (w_lock_hit) begin
              r_state   <= LOCKED;
              r_match   <= '0;
              r_blk_rem <= BLK_LOAD;
              r_blk_err <= '0;
            end else if (w_filled && !w_miss) begin
              if (r_match != MATCH_LAST) r_match <= r_match + 1'b1;
            end else begin
              r_match <= '0;
            end
          end
          LOCKED: begin
            r_hist <= w_hist_self;
            r_err  <= w_miss;
            if (w_err_sum == ERR_LIMIT) begin
              r_state <= SEARCH;
              r_match <= '0;
            end else if (r_blk_rem == '0) begin
              r_blk_rem <= BLK_LOAD;
              r_blk_err <= '0;
            end else begin
              r_blk_rem <= r_blk_rem - 1'b1;
              r_blk_err <= w_err_sum;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

  assign o_lock = (r_state == LOCKED);
  assign o_err  = r_err;

`ifdef PRBS_CHK_COUNTERS_EN
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (i_clear) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_count) begin
      if (~&r_bit_cnt)          r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_miss && ~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_bit_cnt = r_bit_cnt;
  assign o_err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused  = i_clear ^ w_count;
  assign o_bit_cnt = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: rtl/prbs_checker_qi.sv
// Dual-lane PRBS9 checker for I and Q; the lanes are independent instances.
// Optional counters are enabled with PRBS_CHK_COUNTERS_EN.
module prbs_checker_qi
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int BLOCK_LEN = 64,
  parameter int LOSS_THR  = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             i_reset_n,
  prbs_checker_qi_if.slave bus
);

  prbs9_lane_chk #(
    .LOCK_CNT  (LOCK_CNT),
    .BLOCK_LEN (BLOCK_LEN),
    .LOSS_THR  (LOSS_THR),
    .CNT_W     (CNT_W)
  ) u_lane_i (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .i_enable  (bus.i_enable),
    .i_valid   (bus.i_valid),
    .i_bit     (bus.i_bitI),
    .i_clear   (bus.i_clear),
    .o_lock    (bus.o_lockI),
    .o_err     (bus.o_errI),
    .o_bit_cnt (bus.o_bitCntI),
    .o_err_cnt (bus.o_errCntI)
  );

  prbs9_lane_chk #(
    .LOCK_CNT  (LOCK_CNT),
    .BLOCK_LEN (BLOCK_LEN),
    .LOSS_THR  (LOSS_THR),
    .CNT_W     (CNT_W)
  ) u_lane_q (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .i_enable  (bus.i_enable),
    .i_valid   (bus.i_valid),
    .i_bit     (bus.i_bitQ),
    .i_clear   (bus.i_clear),
    .o_lock    (bus.o_lockQ),
    .o_err     (bus.o_errQ),
    .o_bit_cnt (bus.o_bitCntQ),
    .o_err_cnt (bus.o_errCntQ)
  );

endmodule

// File: tb/tb_prbs_checker_qi.sv
// Scoreboard bench for prbs_checker_qi: driver pushes expected outputs, monitor pops and compares.
module tb_prbs_checker_qi;

  localparam int CNT_W = 32;
`ifdef PRBS_CHK_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    bit          chk_lock;
    bit          lock_i;
    bit          lock_q;
    bit          err_i;
    bit          err_q;
    bit          chk_cnt;
    logic [31:0] bc_i;
    logic [31:0] bc_q;
    logic [31:0] ec_i;
    logic [31:0] ec_q;
  } exp_t;

  logic clock     = 1'b0;
  logic i_reset_n = 1'b0;

  prbs_checker_qi_if #(.CNT_W(CNT_W)) bus ();

  prbs_checker_qi #(
    .LOCK_CNT  (16),
    .BLOCK_LEN (64),
    .LOSS_THR  (8),
    .CNT_W     (CNT_W)
  ) dut (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  exp_t        sb_q[$];
  exp_t        e;
  exp_t        me;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [8:0]  g_i;
  logic [8:0]  g_q;
  int          m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, " lockI"},    32'(bus.o_lockI), 32'd0);
    chk({tag, " lockQ"},    32'(bus.o_lockQ), 32'd0);
    chk({tag, " errI"},     32'(bus.o_errI),  32'd0);
    chk({tag, " errQ"},     32'(bus.o_errQ),  32'd0);
    chk({tag, " bitCntI"},  bus.o_bitCntI, 32'd0);
    chk({tag, " bitCntQ"},  bus.o_bitCntQ, 32'd0);
    chk({tag, " errCntI"},  bus.o_errCntI, 32'd0);
    chk({tag, " errCntQ"},  bus.o_errCntQ, 32'd0);
  endtask

  function automatic exp_t mk(input string tag, input bit li, input bit lq, input bit ei, input bit eq);
    exp_t r;
    r.tag = tag; r.chk_lock = 1'b1;
    r.lock_i = li; r.lock_q = lq; r.err_i = ei; r.err_q = eq;
    r.chk_cnt = 1'b0; r.bc_i = '0; r.bc_q = '0; r.ec_i = '0; r.ec_q = '0;
    return r;
  endfunction

  // counts are only expected to move when the counter build is selected
  function automatic exp_t with_cnt(input exp_t x, input int bi, input int bq, input int ei, input int eq);
    exp_t r = x;
    r.chk_cnt = 1'b1;
    r.bc_i = CNT_EN ? 32'(bi) : 32'd0;
    r.bc_q = CNT_EN ? 32'(bq) : 32'd0;
    r.ec_i = CNT_EN ? 32'(ei) : 32'd0;
    r.ec_q = CNT_EN ? 32'(eq) : 32'd0;
    return r;
  endfunction

  task automatic step(input bit en, input bit vld, input bit flip, input bit clr, input bit zero, input exp_t x);
    logic b_i, b_q;
    @(negedge clock);
    if (zero) begin
      b_i = 1'b0; b_q = 1'b0;
    end else if (en && vld) begin
      b_i = g_i[4] ^ g_i[8]; g_i = {g_i[7:0], b_i};
      b_q = g_q[4] ^ g_q[8]; g_q = {g_q[7:0], b_q};
    end else begin
      b_i = 1'($urandom); b_q = 1'($urandom);
    end
    bus.i_enable = en;
    bus.i_valid  = vld;
    bus.i_bitI   = b_i ^ flip;
    bus.i_bitQ   = b_q;
    bus.i_clear  = clr;
    sb_q.push_back(x);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        me = sb_q.pop_front();
        if (me.chk_lock) begin
          chk({me.tag, " lockI"}, 32'(bus.o_lockI), 32'(me.lock_i));
          chk({me.tag, " lockQ"}, 32'(bus.o_lockQ), 32'(me.lock_q));
          chk({me.tag, " errI"},  32'(bus.o_errI),  32'(me.err_i));
          chk({me.tag, " errQ"},  32'(bus.o_errQ),  32'(me.err_q));
        end
        if (me.chk_cnt) begin
          chk({me.tag, " bitCntI"}, bus.o_bitCntI, me.bc_i);
          chk({me.tag, " bitCntQ"}, bus.o_bitCntQ, me.bc_q);
          chk({me.tag, " errCntI"}, bus.o_errCntI, me.ec_i);
          chk({me.tag, " errCntQ"}, bus.o_errCntQ, me.ec_q);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d pending, required 0", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_enable = 1'b0; bus.i_valid = 1'b0;
    bus.i_bitI = 1'b0; bus.i_bitQ = 1'b0; bus.i_clear = 1'b0;
    g_i = 9'b010101011;
    g_q = 9'b111111110;
    #12;
    rst_chk("reset");
    @(negedge clock);
    i_reset_n = 1'b1;

    // continuous stream: lock at bit 25, single error at 200, burst loss at 1001..1008, clear at 1060
    for (int n = 1; n <= 1070; n++) begin
      e = mk($sformatf("stream%0d", n),
             (n >= 25 && n <= 1007) || n >= 1024,
             n >= 25,
             n == 200 || (n >= 1001 && n <= 1008),
             1'b0);
      case (n)
        100:  e = with_cnt(e, 75, 75, 0, 0);
        200:  e = with_cnt(e, 175, 175, 1, 0);
        1000: e = with_cnt(e, 975, 975, 1, 0);
        1008: e = with_cnt(e, 983, 983, 9, 0);
        1050: e = with_cnt(e, 1009, 1025, 9, 0);
        1060: e = with_cnt(e, 0, 0, 0, 0);
        1061: e = with_cnt(e, 1, 1, 0, 0);
        1070: e = with_cnt(e, 10, 10, 0, 0);
        default: ;
      endcase
      step(1'b1, 1'b1, n == 200 || (n >= 1001 && n <= 1008), n == 1060, 1'b0, e);
    end

    @(negedge clock);
    #1;
    i_reset_n = 1'b0;
    #1;
    rst_chk("midlock_rst");
    bus.i_enable = 1'b0; bus.i_valid = 1'b0;
    @(negedge clock);
    i_reset_n = 1'b1;
    g_i = 9'b010101011;
    g_q = 9'b111111110;

    // valid on even cycles only, enable held low over cycles 30..39
    m = 0;
    for (int c = 0; c < 140; c++) begin
      if ((c % 2 == 0) && !(c >= 30 && c < 40)) m++;
      e = mk($sformatf("gapped%0d", c), m >= 25, m >= 25, 1'b0, 1'b0);
      if (c == 139) e = with_cnt(e, m - 25, m - 25, 0, 0);
      step(!(c >= 30 && c < 40), c % 2 == 0, 1'b0, 1'b0, 1'b0, e);
    end

    @(negedge clock);
    #1;
    i_reset_n = 1'b0;
    bus.i_enable = 1'b0; bus.i_valid = 1'b0;
    @(negedge clock);
    i_reset_n = 1'b1;

    for (int c = 0; c < 100; c++) begin
      e = mk($sformatf("zeros%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
      if (c == 99) e = with_cnt(e, 0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, e);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
